// File: rtl/com_uart_pkg.sv
// Shared constants, state encodings and helpers for the COM serial port.
package com_uart_pkg;

  // Memory-mapped register addresses decoded by the memory controller
  localparam logic [31:0] COM_DATA_ADDR = 32'h1FD0_03F8;
  localparam logic [31:0] COM_STAT_ADDR = 32'h1FD0_03FC;

  // Default line configuration
  localparam int DEF_CLK_FREQ   = 50_000_000;
  localparam int DEF_BAUD       = 115_200;
  localparam int DEF_OVERSAMPLE = 16;

  // 8N1 frame constants
  localparam int   FRAME_DATA_BITS = 8;
  localparam logic START_BIT_LEVEL = 1'b0;
  localparam logic STOP_BIT_LEVEL  = 1'b1;

  // TX_ARM holds the line idle until the next oversample tick so every
  // transmitted bit is exactly OVERSAMPLE ticks wide.
  typedef enum logic [2:0] {TX_IDLE, TX_ARM, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // RX_BREAK waits for the line to return high after a framing error.
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  // Clock cycles per oversample tick (integer divide)
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/com_uart_rx_fifo.sv
// Small first-word-fall-through FIFO for received bytes; head is 0 when empty.
module com_rx_fifo #(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr_reg];

  // Storage array write; contents are qualified by count, so no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/com_uart.sv
// 8N1 UART behind the COM_DATA/COM_STAT registers: 16x oversampled RX into a
// small FIFO, tick-paced TX, and sticky error flags.
module com_uart
  import com_uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD       = DEF_BAUD,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int FIFO_AW    = 2
) (
  input  logic       clk50M,
  input  logic       rst_n,
  input  logic       enable_com_write,
  input  logic [7:0] com_data_out,
  output logic       com_write_ready,
  output logic [7:0] com_data_in,
  output logic       com_read_ready,
  input  logic       int_com_ack,
  input  logic       uart_rxd,
  output logic       uart_txd,
  input  logic       err_clear,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       tx_drop
);

  localparam int         DIV          = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam logic [15:0] DIV_LAST    = 16'(DIV - 1);
  localparam logic [7:0] OS_LAST      = 8'(OVERSAMPLE - 1);
  localparam logic [7:0] OS_HALF_LAST = 8'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0] BIT_LAST     = 3'(FRAME_DATA_BITS - 1);

  logic [15:0] div_cnt_reg;
  logic        tick;

  tx_state_t tx_state_reg, tx_state_next;
  logic [7:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0] tx_bit_reg, tx_bit_next;
  logic [7:0] tx_shift_reg, tx_shift_next;
  logic       txd_reg, txd_next;
  logic       tx_drop_set;

  logic       rxd_s1_reg, rxd_s2_reg, rxd_s3_reg;
  rx_state_t  rx_state_reg, rx_state_next;
  logic [7:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0] rx_bit_reg, rx_bit_next;
  logic [7:0] rx_shift_reg, rx_shift_next;
  logic       rx_push_req;
  logic       frame_err_set;

  logic ack_prev_reg;
  logic ack_rise;
  logic fifo_full;
  logic fifo_empty;
  logic overrun_set;
  logic rx_overrun_reg, rx_frame_err_reg, tx_drop_reg;

  assign tick = (div_cnt_reg == DIV_LAST);

  // Free-running oversample divider; tick fires on the DIV-1 -> 0 wrap
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n)    div_cnt_reg <= '0;
    else if (tick) div_cnt_reg <= '0;
    else           div_cnt_reg <= div_cnt_reg + 16'd1;
  end

  // ---------------- Transmitter ----------------
  assign uart_txd        = txd_reg;
  assign com_write_ready = (tx_state_reg == TX_IDLE);

  // TX state register; txd resets straight to idle-high
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      txd_reg      <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      txd_reg      <= tx_state_next == TX_IDLE ? 1'b1 : txd_next;
    end
  end

  // TX next-state: each bit lasts OVERSAMPLE ticks, LSB first
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    txd_next      = txd_reg;
    tx_drop_set   = enable_com_write && (tx_state_reg != TX_IDLE);
    case (tx_state_reg)
      TX_IDLE: begin
        txd_next = STOP_BIT_LEVEL;
        if (enable_com_write) begin
          tx_shift_next = com_data_out;
          tx_state_next = TX_ARM;
        end
      end
      TX_ARM: if (tick) begin
        txd_next      = START_BIT_LEVEL;
        tx_cnt_next   = '0;
        tx_state_next = TX_START;
      end
      TX_START: if (tick) begin
        if (tx_cnt_reg == OS_LAST) begin
          tx_cnt_next   = '0;
          tx_bit_next   = '0;
          txd_next      = tx_shift_reg[0];
          tx_state_next = TX_DATA;
        end else tx_cnt_next = tx_cnt_reg + 8'd1;
      end
      TX_DATA: if (tick) begin
        if (tx_cnt_reg == OS_LAST) begin
          tx_cnt_next = '0;
          if (tx_bit_reg == BIT_LAST) begin
            txd_next      = STOP_BIT_LEVEL;
            tx_state_next = TX_STOP;
          end else begin
            tx_shift_next = tx_shift_reg >> 1;
            txd_next      = tx_shift_reg[1];
            tx_bit_next   = tx_bit_reg + 3'd1;
          end
        end else tx_cnt_next = tx_cnt_reg + 8'd1;
      end
      TX_STOP: if (tick) begin
        if (tx_cnt_reg == OS_LAST) begin
          tx_cnt_next   = '0;
          tx_state_next = TX_IDLE;
        end else tx_cnt_next = tx_cnt_reg + 8'd1;
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  // ---------------- Receiver ----------------
  // Two-stage synchroniser plus one history stage for falling-edge detection
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1_reg <= 1'b1;
      rxd_s2_reg <= 1'b1;
      rxd_s3_reg <= 1'b1;
    end else begin
      rxd_s1_reg <= uart_rxd;
      rxd_s2_reg <= rxd_s1_reg;
      rxd_s3_reg <= rxd_s2_reg;
    end
  end

  // RX state register; a partial byte is simply abandoned on reset
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
    end
  end

  // RX next-state: validate start at half bit, then sample once per bit
  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_push_req   = 1'b0;
    frame_err_set = 1'b0;
    case (rx_state_reg)
      RX_IDLE: if (rxd_s3_reg && !rxd_s2_reg) begin
        rx_cnt_next   = '0;
        rx_state_next = RX_START;
      end
      RX_START: if (tick) begin
        if (rx_cnt_reg == OS_HALF_LAST) begin
          rx_cnt_next = '0;
          rx_bit_next = '0;
          rx_state_next = (rxd_s2_reg == START_BIT_LEVEL) ? RX_DATA : RX_IDLE;
        end else rx_cnt_next = rx_cnt_reg + 8'd1;
      end
      RX_DATA: if (tick) begin
        if (rx_cnt_reg == OS_LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rxd_s2_reg, rx_shift_reg[7:1]};
          if (rx_bit_reg == BIT_LAST) rx_state_next = RX_STOP;
          else                        rx_bit_next   = rx_bit_reg + 3'd1;
        end else rx_cnt_next = rx_cnt_reg + 8'd1;
      end
      RX_STOP: if (tick) begin
        if (rx_cnt_reg == OS_LAST) begin
          rx_cnt_next = '0;
          if (rxd_s2_reg == STOP_BIT_LEVEL) begin
            rx_push_req   = 1'b1;
            rx_state_next = RX_IDLE;
          end else begin
            frame_err_set = 1'b1;
            rx_state_next = RX_BREAK;
          end
        end else rx_cnt_next = rx_cnt_reg + 8'd1;
      end
      RX_BREAK: if (rxd_s2_reg) rx_state_next = RX_IDLE;
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  // ---------------- FIFO, ack edge and sticky flags ----------------
  assign ack_rise    = int_com_ack && !ack_prev_reg;
  assign overrun_set = rx_push_req && fifo_full && !ack_rise;

  com_rx_fifo #(.AW(FIFO_AW), .DW(8)) u_rx_fifo (
    .clk       (clk50M),
    .rst_n     (rst_n),
    .push      (rx_push_req),
    .push_data (rx_shift_reg),
    .pop       (ack_rise),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (com_data_in)
  );

  assign com_read_ready = !fifo_empty;
  assign rx_overrun     = rx_overrun_reg;
  assign rx_frame_err   = rx_frame_err_reg;
  assign tx_drop        = tx_drop_reg;

  // Ack history and sticky error flags; a set in the clearing cycle wins
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      ack_prev_reg     <= 1'b0;
      rx_overrun_reg   <= 1'b0;
      rx_frame_err_reg <= 1'b0;
      tx_drop_reg      <= 1'b0;
    end else begin
      ack_prev_reg     <= int_com_ack;
      rx_overrun_reg   <= overrun_set   || (rx_overrun_reg   && !err_clear);
      rx_frame_err_reg <= frame_err_set || (rx_frame_err_reg && !err_clear);
      tx_drop_reg      <= tx_drop_set   || (tx_drop_reg      && !err_clear);
    end
  end

endmodule

// File: tb/tb_com_uart.sv
// Self-checking bench for com_uart: table-driven RX frames, hand sequences
// for TX timing / overrun / reset, and randomized traffic against a queue model.
module tb_com_uart;

  localparam int BIT_CLK   = 432;
  localparam int FRAME_CLK = 10 * BIT_CLK;

  logic       clk50M = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable_com_write = 1'b0;
  logic [7:0] com_data_out = 8'h00;
  logic       int_com_ack = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       err_clear = 1'b0;
  logic       com_write_ready;
  logic [7:0] com_data_in;
  logic       com_read_ready;
  logic       uart_txd;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       tx_drop;

  int errors = 0;
  int checks = 0;

  // Behavioural model: FIFO contents as a queue, sticky flags as bits
  logic [7:0] model_q[$];
  logic       model_overrun = 1'b0;
  logic       model_ferr = 1'b0;

  logic [9:0] tx_bits;
  int         tx_fall_n;
  int         tx_ready_n;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_ready;
    logic [7:0] exp_head;
    logic       exp_ferr;
    logic       ack_after;
    logic       clear_after;
  } rx_vec_t;

  rx_vec_t vecs[3];

  com_uart dut (
    .clk50M           (clk50M),
    .rst_n            (rst_n),
    .enable_com_write (enable_com_write),
    .com_data_out     (com_data_out),
    .com_write_ready  (com_write_ready),
    .com_data_in      (com_data_in),
    .com_read_ready   (com_read_ready),
    .int_com_ack      (int_com_ack),
    .uart_rxd         (uart_rxd),
    .uart_txd         (uart_txd),
    .err_clear        (err_clear),
    .rx_overrun       (rx_overrun),
    .rx_frame_err     (rx_frame_err),
    .tx_drop          (tx_drop)
  );

  always #10 clk50M = ~clk50M;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      $display("check %s: 0x%0h ok", name, act);
    end
  endtask

  // Drive one 8N1 frame on the RX line, then a short idle gap
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = frame[i];
      repeat (BIT_CLK) @(negedge clk50M);
    end
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk50M);
  endtask

  task automatic do_ack();
    @(negedge clk50M) int_com_ack = 1'b1;
    @(negedge clk50M) int_com_ack = 1'b0;
    @(negedge clk50M);
  endtask

  task automatic pulse_clear();
    @(negedge clk50M) err_clear = 1'b1;
    @(negedge clk50M) err_clear = 1'b0;
    @(negedge clk50M);
  endtask

  // Strobe a byte, optionally strobe again at cycle second_at, and capture
  // the line at the centre of each of the 10 bit cells until write_ready returns
  task automatic tx_send(input logic [7:0] b, input int second_at, input logic [7:0] b2,
                         output logic [9:0] bits, output int fall_n, output int ready_n);
    bits = '1;
    fall_n = 0;
    ready_n = 0;
    @(negedge clk50M);
    enable_com_write = 1'b1;
    com_data_out = b;
    @(negedge clk50M);
    enable_com_write = 1'b0;
    for (int n = 1; n <= 5000; n++) begin
      if (n == second_at) begin
        enable_com_write = 1'b1;
        com_data_out = b2;
      end else if (n == second_at + 1) begin
        enable_com_write = 1'b0;
      end
      if (fall_n == 0 && uart_txd == 1'b0) fall_n = n;
      if (fall_n != 0)
        for (int k = 0; k < 10; k++)
          if (n == fall_n + BIT_CLK / 2 + k * BIT_CLK) bits[k] = uart_txd;
      if (com_write_ready) begin
        ready_n = n;
        break;
      end
      @(negedge clk50M);
    end
    enable_com_write = 1'b0;
  endtask

  task automatic check_tx(input string name, input logic [7:0] b);
    logic [9:0] exp_frame;
    exp_frame = {1'b1, b, 1'b0};
    check({name, "_bits"}, tx_bits, exp_frame);
    check({name, "_busy_span"}, tx_ready_n - tx_fall_n, FRAME_CLK);
    check({name, "_start_delay_ok"}, (tx_fall_n >= 1 && tx_fall_n <= 28), 1);
    check({name, "_txd_idle"}, uart_txd, 1);
  endtask

  function automatic void model_rx(input logic [7:0] b, input logic stop);
    if (!stop) model_ferr = 1'b1;
    else if (model_q.size() < 4) model_q.push_back(b);
    else model_overrun = 1'b1;
  endfunction

  task automatic check_rx_model(input string name);
    check({name, "_ready"}, com_read_ready, model_q.size() > 0);
    check({name, "_head"}, com_data_in, (model_q.size() > 0) ? model_q[0] : 8'h00);
    check({name, "_overrun"}, rx_overrun, model_overrun);
    check({name, "_ferr"}, rx_frame_err, model_ferr);
  endtask

  task automatic ack_model(input string name);
    do_ack();
    if (model_q.size() > 0) void'(model_q.pop_front());
    check_rx_model(name);
  endtask

  initial begin
    vecs[0] = '{8'hA3, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk50M);
    check("rst_txd", uart_txd, 1);
    check("rst_write_ready", com_write_ready, 1);
    check("rst_read_ready", com_read_ready, 0);
    check("rst_data_in", com_data_in, 0);
    check("rst_flags", {rx_overrun, rx_frame_err, tx_drop}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk50M);

    // TX 0x55 timing and bit pattern
    tx_send(8'h55, 0, 8'h00, tx_bits, tx_fall_n, tx_ready_n);
    check_tx("tx55", 8'h55);
    check("tx55_ready_low_min", tx_ready_n - 1 >= FRAME_CLK + 1, 1);
    check("tx55_ready_low_max", tx_ready_n - 1 <= FRAME_CLK + 27, 1);

    // Glitch shorter than half a bit is a false start
    @(negedge clk50M) uart_rxd = 1'b0;
    repeat (100) @(negedge clk50M);
    uart_rxd = 1'b1;
    repeat (600) @(negedge clk50M);
    check("glitch_ready", com_read_ready, 0);
    check("glitch_ferr", rx_frame_err, 0);

    // Table-driven RX frames
    for (int i = 0; i < 3; i++) begin
      send_rx(vecs[i].data, vecs[i].stop);
      check($sformatf("vec%0d_ready", i), com_read_ready, vecs[i].exp_ready);
      check($sformatf("vec%0d_head", i), com_data_in, vecs[i].exp_head);
      check($sformatf("vec%0d_ferr", i), rx_frame_err, vecs[i].exp_ferr);
      if (vecs[i].ack_after) begin
        do_ack();
        check($sformatf("vec%0d_ack_ready", i), com_read_ready, 0);
      end
      if (vecs[i].clear_after) begin
        pulse_clear();
        check($sformatf("vec%0d_clear_ferr", i), rx_frame_err, 0);
      end
    end

    // Five bytes without ack: fifth overruns
    for (int b = 1; b <= 5; b++) begin
      send_rx(8'(b), 1'b1);
      model_rx(8'(b), 1'b1);
      check_rx_model($sformatf("fill%0d", b));
    end
    for (int a = 0; a < 4; a++) ack_model($sformatf("drain%0d", a));
    pulse_clear();
    model_overrun = 1'b0;
    check_rx_model("fill_clear");

    // Second strobe while busy is dropped; first byte goes out intact
    tx_send(8'h96, 100, 8'h69, tx_bits, tx_fall_n, tx_ready_n);
    check_tx("txdrop", 8'h96);
    check("txdrop_flag", tx_drop, 1);
    ack_model("ack_empty");
    pulse_clear();
    check("txdrop_clear", tx_drop, 0);

    // Randomized concurrent TX and RX against the model
    for (int it = 0; it < 5; it++) begin
      logic [7:0] rb;
      logic [7:0] tb;
      logic       rstop;
      int         nacks;
      nacks = $urandom_range(0, 2);
      for (int a = 0; a < nacks; a++) ack_model($sformatf("rand%0d_ack%0d", it, a));
      rb = 8'($urandom);
      tb = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      fork
        send_rx(rb, rstop);
        tx_send(tb, 0, 8'h00, tx_bits, tx_fall_n, tx_ready_n);
      join
      model_rx(rb, rstop);
      $display("rand%0d: rx=0x%0h stop=%0d tx=0x%0h", it, rb, rstop, tb);
      check_rx_model($sformatf("rand%0d", it));
      check_tx($sformatf("rand%0d_tx", it), tb);
      if ($urandom_range(0, 2) == 0) begin
        pulse_clear();
        model_overrun = 1'b0;
        model_ferr = 1'b0;
        check_rx_model($sformatf("rand%0d_clr", it));
      end
    end
    check("rand_no_drop", tx_drop, 0);

    // Asynchronous reset in the middle of a TX data bit
    pulse_clear();
    model_overrun = 1'b0;
    model_ferr = 1'b0;
    while (model_q.size() > 0) ack_model("pre_rst_drain");
    send_rx(8'h5A, 1'b1);
    model_rx(8'h5A, 1'b1);
    check_rx_model("pre_rst");
    @(negedge clk50M);
    enable_com_write = 1'b1;
    com_data_out = 8'hC3;
    @(negedge clk50M);
    enable_com_write = 1'b0;
    repeat (1500) @(negedge clk50M);
    check("pre_rst_txd_low", uart_txd, 0);
    check("pre_rst_busy", com_write_ready, 0);
    #3 rst_n = 1'b0;
    #1;
    check("rst_async_txd", uart_txd, 1);
    check("rst_async_ready", com_write_ready, 1);
    @(negedge clk50M) rst_n = 1'b1;
    model_q.delete();
    repeat (5) @(negedge clk50M);
    check("post_rst_read_ready", com_read_ready, 0);
    check("post_rst_data_in", com_data_in, 0);
    check("post_rst_txd", uart_txd, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
